srio_type9_unpack: RTL and testbench
====================================

Name: srio_type9_unpack

Overview:
Receive-side counterpart of the Type 9 packer. Consumes SRIO Type 9 data-streaming packets (one header beat followed by payload beats) from the SRIO core's receive AXIS port and strips the header. Filters on stream ID and forwards payload only, with TKEEP on the final beat, to the DMA/user stream. Keeps packet, drop and length-error counters for software.

Parameters:
CNT_W, 16, width of each status counter (wraps modulo 2^CNT_W)
MAX_LEN, 65535, largest accepted header length in bytes; a larger value is a length error

Ports:
AXIS_ACLK  in  1  clock for all logic
AXIS_ARESETN  in  1  reset, synchronous, active-low
S_AXIS_TVALID  in  1  SRIO receive stream valid
S_AXIS_TREADY  out  1  SRIO receive stream ready
S_AXIS_TDATA  in  64  beat 0 is the header; later beats are payload
S_AXIS_TLAST  in  1  last beat of the packet
S_AXIS_TUSER  in  32  srcdest {src[31:16], dest[15:0]}; sampled on the header beat
M_AXIS_TVALID  out  1  payload valid
M_AXIS_TREADY  in  1  payload ready
M_AXIS_TDATA  out  64  payload
M_AXIS_TKEEP  out  8  byte enables; bit 7 corresponds to TDATA[63:56]
M_AXIS_TLAST  out  1  last payload beat
M_AXIS_TUSER  out  32  srcdest latched from the header beat
cfg_enable  in  1  0 = drop every packet
cfg_stream_id  in  16  required stream ID
cfg_stream_mask  in  16  1 = compare this bit, 0 = ignore it
pkt_count  out  CNT_W  packets forwarded
drop_count  out  CNT_W  packets discarded by the filter, by enable, or for zero length
err_count  out  CNT_W  packets with a length error

Behaviour:
- Header beat fields:
  - [63:48] streamID
  - [47:40] cos (ignored)
  - [39:36] ftype (must be 4'h9)
  - [35:32] reserved
  - [31:16] length in bytes
  - [15:0] reserved
- Expected beats: exp = ceil(length/8).
- Reset values: M_AXIS_TVALID=0, TDATA=0, TKEEP=0, TLAST=0, TUSER=0, all counters=0, state=HDR. S_AXIS_TREADY follows its combinational definition below.
- Output stage: one register stage, so latency is 1 cycle from input acceptance to M_AXIS_TVALID.
  - S_AXIS_TREADY = !M_AXIS_TVALID || M_AXIS_TREADY in HDR and PASS; constant 1 in DROP and DRAIN.
  - M outputs are held stable while TVALID=1 and TREADY=0.
- State HDR (on an accepted beat):
  - Match condition: ftype==9, cfg_enable=1, ((streamID ^ cfg_stream_id) & cfg_stream_mask)==0.
  - If TLAST=1 on the header: length==0 -> drop_count++; length!=0 -> err_count++. Nothing is forwarded. Stay in HDR.
  - Else if length==0, or no match: drop_count++, go to DROP.
  - Else if length > MAX_LEN: err_count++, go to DROP.
  - Else: latch srcdest, load beat counter with exp, go to PASS.
- State PASS (each accepted beat):
  - The beat is moved to the output register and the counter decrements.
  - TKEEP = 8'hFF, except on the final expected beat: 8'hFF << (8 - length[2:0]) when length[2:0]!=0.
  - Final expected beat with S TLAST=1: M TLAST=1, pkt_count++, go to HDR.
  - Final expected beat with S TLAST=0 (packet too long): M TLAST=1, err_count++, go to DRAIN.
  - S TLAST=1 before the final expected beat (packet too short): forward that beat with TLAST=1 and TKEEP=8'hFF, err_count++ (pkt_count is not incremented), go to HDR.
- DROP / DRAIN: discard beats until an accepted S TLAST, then go to HDR. No output.
- Simultaneous events: a new header may be accepted in the same cycle the previous last beat drains from the output register.
- cfg_* inputs are sampled only on the header beat; changes mid-packet have no effect on that packet.
- A counter increment and a wrap in the same cycle simply wraps. Each packet increments exactly one counter.
- Reset asserted mid-packet: all state is cleared. Input beats after reset are treated as a header.

Test Plan:
- Header {sid=16'h0012, ftype=9, len=24}, 3 payload beats, mask=16'hFFFF, id=16'h0012 -> 3 output beats, TKEEP FF/FF/FF, TLAST on beat 3, TUSER = input srcdest, pkt_count=1.
- len=13 with 2 payload beats -> beat 2 has TKEEP=8'hF8 and TLAST=1; len=8 with 1 beat -> TKEEP=8'hFF.
- sid=16'h0013, id=16'h0012, mask=16'hFFFF -> no output, drop_count=1; mask=16'hFFF0 -> forwarded.
- len=32, TLAST on payload beat 2 -> 2 beats out, TLAST on beat 2, err_count=1; len=8 with 3 beats -> 1 beat out with TLAST, 2 beats drained, err_count=1.
- Back-to-back packets with M_AXIS_TREADY toggling 1010... -> no lost or duplicated beats, TDATA stable while stalled, no bubble between packets when TREADY=1.
- Reset pulsed mid-PASS, then a clean packet -> outputs 0 during reset, counters 0, the new packet forwards correctly.

Source files
------------

// File: rtl/srio_type9_unpack.sv
// Type 9 data-streaming receive unpacker: strips the header beat, filters on stream ID,
// forwards the payload with TKEEP on the final beat, and counts forwarded, dropped and errored packets.
module srio_type9_unpack #(
  parameter int CNT_W   = 16,
  parameter int MAX_LEN = 65535
) (
  input  logic             AXIS_ACLK,
  input  logic             AXIS_ARESETN,
  input  logic             S_AXIS_TVALID,
  output logic             S_AXIS_TREADY,
  input  logic [63:0]      S_AXIS_TDATA,
  input  logic             S_AXIS_TLAST,
  input  logic [31:0]      S_AXIS_TUSER,
  output logic             M_AXIS_TVALID,
  input  logic             M_AXIS_TREADY,
  output logic [63:0]      M_AXIS_TDATA,
  output logic [7:0]       M_AXIS_TKEEP,
  output logic             M_AXIS_TLAST,
  output logic [31:0]      M_AXIS_TUSER,
  input  logic             cfg_enable,
  input  logic [15:0]      cfg_stream_id,
  input  logic [15:0]      cfg_stream_mask,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {HDR, PASS, DROP, DRAIN} state_t;

  localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

  state_t             state_q, state_d;
  logic [13:0]        cnt_q, cnt_d;
  logic [2:0]         rem_q, rem_d;
  logic               m_valid_q, m_valid_d;
  logic [63:0]        m_data_q, m_data_d;
  logic [7:0]         m_keep_q, m_keep_d;
  logic               m_last_q, m_last_d;
  logic [31:0]        m_user_q, m_user_d;
  logic [CNT_W-1:0]   pkt_q, drop_q, err_q;
  logic               inc_pkt, inc_drop, inc_err;

  logic [15:0]        hdr_sid, hdr_len;
  logic [3:0]         hdr_ftype;
  logic               hdr_match, hdr_too_long;
  logic [16:0]        len_plus;
  logic [13:0]        hdr_exp;
  logic               s_ready, accept, last_exp;
  logic [7:0]         final_keep;
  logic               unused_len_bits;

  assign hdr_sid      = S_AXIS_TDATA[63:48];
  assign hdr_ftype    = S_AXIS_TDATA[39:36];
  assign hdr_len      = S_AXIS_TDATA[31:16];
  assign hdr_match    = (hdr_ftype == 4'h9) && cfg_enable &&
                        (((hdr_sid ^ cfg_stream_id) & cfg_stream_mask) == 16'h0000);
  assign hdr_too_long = {1'b0, hdr_len} > MAX_LEN_W;
  // Beat count is ceil(length/8); the 17-bit sum avoids overflow at length 65535.
  assign len_plus        = {1'b0, hdr_len} + 17'd7;
  assign hdr_exp         = len_plus[16:3];
  assign unused_len_bits = ^len_plus[2:0];

  assign s_ready    = (state_q == DROP) || (state_q == DRAIN) || !m_valid_q || M_AXIS_TREADY;
  assign accept     = S_AXIS_TVALID && s_ready;
  assign last_exp   = (cnt_q == 14'd1);
  assign final_keep = (rem_q == 3'd0) ? 8'hFF : (8'hFF << (4'd8 - {1'b0, rem_q}));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    m_valid_d = m_valid_q && !M_AXIS_TREADY;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_user_d  = m_user_q;
    inc_pkt   = 1'b0;
    inc_drop  = 1'b0;
    inc_err   = 1'b0;
    if (accept) begin
      case (state_q)
        HDR: begin
          if (S_AXIS_TLAST) begin
            if (hdr_len == 16'd0) inc_drop = 1'b1;
            else                  inc_err  = 1'b1;
          end else if (hdr_len == 16'd0 || !hdr_match) begin
            inc_drop = 1'b1;
            state_d  = DROP;
          end else if (hdr_too_long) begin
            inc_err = 1'b1;
            state_d = DROP;
          end else begin
            m_user_d = S_AXIS_TUSER;
            cnt_d    = hdr_exp;
            rem_d    = hdr_len[2:0];
            state_d  = PASS;
          end
        end
        PASS: begin
          m_valid_d = 1'b1;
          m_data_d  = S_AXIS_TDATA;
          m_keep_d  = last_exp ? final_keep : 8'hFF;
          m_last_d  = last_exp || S_AXIS_TLAST;
          cnt_d     = cnt_q - 14'd1;
          if (last_exp) begin
            if (S_AXIS_TLAST) begin
              inc_pkt = 1'b1;
              state_d = HDR;
            end else begin
              inc_err = 1'b1;
              state_d = DRAIN;
            end
          end else if (S_AXIS_TLAST) begin
            inc_err = 1'b1;
            state_d = HDR;
          end
        end
        default: begin
          if (S_AXIS_TLAST) state_d = HDR;
        end
      endcase
    end
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      state_q   <= HDR;
      cnt_q     <= '0;
      rem_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_user_q  <= '0;
      pkt_q     <= '0;
      drop_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_user_q  <= m_user_d;
      if (inc_pkt)  pkt_q  <= pkt_q  + CNT_W'(1);
      if (inc_drop) drop_q <= drop_q + CNT_W'(1);
      if (inc_err)  err_q  <= err_q  + CNT_W'(1);
    end
  end

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TDATA  = m_data_q;
  assign M_AXIS_TKEEP  = m_keep_q;
  assign M_AXIS_TLAST  = m_last_q;
  assign M_AXIS_TUSER  = m_user_q;
  assign pkt_count     = pkt_q;
  assign drop_count    = drop_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_srio_type9_unpack.sv
// Directed bench for srio_type9_unpack: stimulus pushes expected output beats into a
// scoreboard queue, and a monitor pops and compares on every output handshake.
module tb_srio_type9_unpack;

  logic        AXIS_ACLK = 1'b0;
  logic        AXIS_ARESETN;
  logic        S_AXIS_TVALID, S_AXIS_TREADY, S_AXIS_TLAST;
  logic [63:0] S_AXIS_TDATA;
  logic [31:0] S_AXIS_TUSER;
  logic        M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TLAST;
  logic [63:0] M_AXIS_TDATA;
  logic [7:0]  M_AXIS_TKEEP;
  logic [31:0] M_AXIS_TUSER;
  logic        cfg_enable;
  logic [15:0] cfg_stream_id, cfg_stream_mask;
  logic [15:0] pkt_count, drop_count, err_count;

  srio_type9_unpack #(.CNT_W(16), .MAX_LEN(65535)) dut (
    .AXIS_ACLK(AXIS_ACLK), .AXIS_ARESETN(AXIS_ARESETN),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TUSER(S_AXIS_TUSER),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TUSER(M_AXIS_TUSER),
    .cfg_enable(cfg_enable), .cfg_stream_id(cfg_stream_id), .cfg_stream_mask(cfg_stream_mask),
    .pkt_count(pkt_count), .drop_count(drop_count), .err_count(err_count)
  );

  always #5 AXIS_ACLK = ~AXIS_ACLK;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [31:0] u;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_beats  = 0;
  int    exp_pkt  = 0;
  int    exp_drop = 0;
  int    exp_err  = 0;
  logic  toggle_mode  = 1'b0;
  logic  tready_const = 1'b1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] hdr(input logic [15:0] sid, input logic [3:0] ft, input logic [15:0] len);
    return {sid, 8'h00, ft, 4'h0, len, 16'h0000};
  endfunction

  function automatic logic [63:0] mk(input logic [7:0] tag, input int i);
    return {8'hD0, tag, 40'h0, 8'(i)};
  endfunction

  task automatic expb(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [31:0] u);
    beat_t b;
    b.d = d; b.k = k; b.l = l; b.u = u;
    sb.push_back(b);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the beat is accepted.
  task automatic send_beat(input logic [63:0] d, input logic l, input logic [31:0] u);
    bit ok = 1'b0;
    S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = d; S_AXIS_TLAST = l; S_AXIS_TUSER = u;
    for (int k = 0; k < 200; k++) begin
      @(negedge AXIS_ACLK);
      if (S_AXIS_TREADY) begin ok = 1'b1; break; end
    end
    @(posedge AXIS_ACLK); #1;
    if (!ok) begin
      n_checks++;
      $display("FAIL s_tready_timeout: beat %0h never accepted", d);
    end
  endtask

  task automatic send_pkt(input logic [15:0] sid, input logic [3:0] ft, input logic [15:0] len,
                          input int nbeats, input logic [31:0] u, input logic [7:0] tag);
    send_beat(hdr(sid, ft, len), nbeats == 0, u);
    for (int i = 1; i <= nbeats; i++) send_beat(mk(tag, i), i == nbeats, ~u);
    S_AXIS_TVALID = 1'b0;
  endtask

  task automatic check_counters(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge AXIS_ACLK);
      if (sb.size() == 0 && !M_AXIS_TVALID) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL %s_idle: %0d beats still expected", name, sb.size());
    end
    chk({name, "_pkt"},  128'(pkt_count),  128'(exp_pkt));
    chk({name, "_drop"}, 128'(drop_count), 128'(exp_drop));
    chk({name, "_err"},  128'(err_count),  128'(exp_err));
    @(posedge AXIS_ACLK); #1;
  endtask

  initial begin
    forever begin
      @(posedge AXIS_ACLK); #1;
      if (toggle_mode) M_AXIS_TREADY = ~M_AXIS_TREADY;
      else             M_AXIS_TREADY = tready_const;
    end
  end

  // Monitor: handshake compare plus output stability while stalled.
  initial begin
    beat_t snap;
    bit    stalled = 1'b0;
    forever begin
      @(negedge AXIS_ACLK);
      if (!AXIS_ARESETN) begin
        stalled = 1'b0;
      end else begin
        if (stalled)
          chk("stall_hold", 128'({M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TUSER}),
              128'({1'b1, snap}));
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          n_beats++;
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: data %0h with empty scoreboard", M_AXIS_TDATA);
          end else begin
            chk($sformatf("beat%0d", n_beats),
                128'({M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TUSER}), 128'(sb.pop_front()));
          end
        end
        stalled = M_AXIS_TVALID && !M_AXIS_TREADY;
        snap    = {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TUSER};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    AXIS_ARESETN = 1'b0; S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TLAST = 1'b0;
    S_AXIS_TUSER = '0; M_AXIS_TREADY = 1'b1;
    cfg_enable = 1'b1; cfg_stream_id = 16'h0012; cfg_stream_mask = 16'hFFFF;
    repeat (3) @(posedge AXIS_ACLK);
    @(negedge AXIS_ACLK);
    chk("rst_tvalid", 128'(M_AXIS_TVALID), 128'(0));
    chk("rst_tdata",  128'(M_AXIS_TDATA),  128'(0));
    chk("rst_tkeep",  128'(M_AXIS_TKEEP),  128'(0));
    chk("rst_tlast",  128'(M_AXIS_TLAST),  128'(0));
    chk("rst_tuser",  128'(M_AXIS_TUSER),  128'(0));
    chk("rst_counts", 128'({pkt_count, drop_count, err_count}), 128'(0));
    chk("rst_sready", 128'(S_AXIS_TREADY), 128'(1));
    @(posedge AXIS_ACLK); #1;
    AXIS_ARESETN = 1'b1;
    repeat (2) @(posedge AXIS_ACLK); #1;

    // Basic 24-byte packet
    expb(mk(8'h01, 1), 8'hFF, 1'b0, 32'h0001_0002);
    expb(mk(8'h01, 2), 8'hFF, 1'b0, 32'h0001_0002);
    expb(mk(8'h01, 3), 8'hFF, 1'b1, 32'h0001_0002);
    send_pkt(16'h0012, 4'h9, 16'd24, 3, 32'h0001_0002, 8'h01);
    exp_pkt++;
    check_counters("basic");

    // Partial final beat, then exact 8 bytes
    expb(mk(8'h02, 1), 8'hFF, 1'b0, 32'hAAAA_5555);
    expb(mk(8'h02, 2), 8'hF8, 1'b1, 32'hAAAA_5555);
    send_pkt(16'h0012, 4'h9, 16'd13, 2, 32'hAAAA_5555, 8'h02);
    expb(mk(8'h03, 1), 8'hFF, 1'b1, 32'h1234_5678);
    send_pkt(16'h0012, 4'h9, 16'd8, 1, 32'h1234_5678, 8'h03);
    exp_pkt += 2;
    check_counters("keep");

    // Stream-ID filter: exact mask drops, relaxed mask forwards
    send_pkt(16'h0013, 4'h9, 16'd8, 1, 32'h0000_0004, 8'h04);
    exp_drop++;
    check_counters("filt_drop");
    cfg_stream_mask = 16'hFFF0;
    expb(mk(8'h05, 1), 8'hFF, 1'b1, 32'h0000_0005);
    send_pkt(16'h0013, 4'h9, 16'd8, 1, 32'h0000_0005, 8'h05);
    exp_pkt++;
    check_counters("filt_mask");
    cfg_stream_mask = 16'hFFFF;

    // Short packet (early TLAST), then long packet (drain extras)
    expb(mk(8'h06, 1), 8'hFF, 1'b0, 32'h0000_0006);
    expb(mk(8'h06, 2), 8'hFF, 1'b1, 32'h0000_0006);
    send_pkt(16'h0012, 4'h9, 16'd32, 2, 32'h0000_0006, 8'h06);
    exp_err++;
    check_counters("short");
    expb(mk(8'h07, 1), 8'hFF, 1'b1, 32'h0000_0007);
    send_pkt(16'h0012, 4'h9, 16'd8, 3, 32'h0000_0007, 8'h07);
    exp_err++;
    check_counters("long");

    // Header-only and filtered packets
    send_pkt(16'h0012, 4'h9, 16'd0, 0, 32'h0, 8'h08);
    exp_drop++;
    send_pkt(16'h0012, 4'h9, 16'd16, 0, 32'h0, 8'h08);
    exp_err++;
    send_pkt(16'h0012, 4'h9, 16'd0, 2, 32'h0, 8'h08);
    exp_drop++;
    send_pkt(16'h0012, 4'h8, 16'd8, 1, 32'h0, 8'h08);
    exp_drop++;
    cfg_enable = 1'b0;
    send_pkt(16'h0012, 4'h9, 16'd8, 1, 32'h0, 8'h08);
    exp_drop++;
    cfg_enable = 1'b1;
    check_counters("drops");

    // Back-to-back packets with toggling downstream ready
    toggle_mode = 1'b1;
    expb(mk(8'h10, 1), 8'hFF, 1'b0, 32'h0000_0010);
    expb(mk(8'h10, 2), 8'hFF, 1'b1, 32'h0000_0010);
    expb(mk(8'h11, 1), 8'hF8, 1'b1, 32'h0000_0011);
    expb(mk(8'h12, 1), 8'hFF, 1'b0, 32'h0000_0012);
    expb(mk(8'h12, 2), 8'hFF, 1'b0, 32'h0000_0012);
    expb(mk(8'h12, 3), 8'hF0, 1'b1, 32'h0000_0012);
    send_pkt(16'h0012, 4'h9, 16'd16, 2, 32'h0000_0010, 8'h10);
    send_pkt(16'h0012, 4'h9, 16'd5,  1, 32'h0000_0011, 8'h11);
    send_pkt(16'h0012, 4'h9, 16'd20, 3, 32'h0000_0012, 8'h12);
    exp_pkt += 3;
    check_counters("b2b");
    toggle_mode = 1'b0; tready_const = 1'b1;

    // Reset in the middle of a packet with the output stalled
    tready_const = 1'b0;
    repeat (2) @(posedge AXIS_ACLK); #1;
    send_beat(hdr(16'h0012, 4'h9, 16'd24), 1'b0, 32'h0000_0020);
    send_beat(mk(8'h20, 1), 1'b0, 32'h0);
    S_AXIS_TDATA = mk(8'h20, 2);
    @(posedge AXIS_ACLK); #1;
    AXIS_ARESETN = 1'b0; S_AXIS_TVALID = 1'b0;
    repeat (2) @(posedge AXIS_ACLK);
    @(negedge AXIS_ACLK);
    chk("mid_rst_tvalid", 128'(M_AXIS_TVALID), 128'(0));
    chk("mid_rst_out", 128'({M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TUSER}), 128'(0));
    chk("mid_rst_counts", 128'({pkt_count, drop_count, err_count}), 128'(0));
    exp_pkt = 0; exp_drop = 0; exp_err = 0;
    @(posedge AXIS_ACLK); #1;
    AXIS_ARESETN = 1'b1; tready_const = 1'b1;
    repeat (2) @(posedge AXIS_ACLK); #1;
    expb(mk(8'h21, 1), 8'hFF, 1'b0, 32'h0000_0021);
    expb(mk(8'h21, 2), 8'hF0, 1'b1, 32'h0000_0021);
    send_pkt(16'h0012, 4'h9, 16'd12, 2, 32'h0000_0021, 8'h21);
    exp_pkt++;
    check_counters("post_rst");

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
